residue_select_serializer: RTL and testbench
============================================

Name: residue_select_serializer

Overview:
- Parametrised, registered successor to the combinational residue-channel selector in the reverse-converter datapath.
- Accepts NUM_CH residue channels of WIDTH bits each.
- Direct mode: emits the one channel chosen by sel.
- Scan mode: snapshots all channels and serialises them to the converter core, channel 1 through channel NUM_CH, under a valid/ready handshake.

Parameters:
- WIDTH, 8, bits per residue channel.
- NUM_CH, 7, number of channels; legal range 1..(2^SEL_W - 1).
- SEL_W, 3, width of the channel-select and channel-tag fields.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_bus  in  NUM_CH*WIDTH  channel k (1-based) at bits [k*WIDTH-1 : (k-1)*WIDTH].
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- mode  in  1  0 = direct select, 1 = scan; sampled on accept.
- sel  in  SEL_W  channel for direct mode; sampled on accept; ignored in scan mode.
- out_data  out  WIDTH  selected residue.
- out_ch  out  SEL_W  channel tag of out_data; 0 = null/zero beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  final beat of the current request.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Accept: in_valid && in_ready at a rising edge. Fire: out_valid && out_ready at a rising edge.
- in_ready = !out_valid || (out_ready && out_last). Combinational from out_ready, so requests can run back-to-back with no bubble.
- States:
  - IDLE: out_valid = 0.
  - DIRECT: single beat held.
  - SCAN: k beats, held in a channel counter cnt.
- Transitions:
  - IDLE to DIRECT on accept with mode = 0.
  - IDLE to SCAN on accept with mode = 1.
  - DIRECT or SCAN to IDLE on a fire with out_last = 1 and no simultaneous accept.
  - A fire with out_last = 1 together with an accept enters the new request's state directly.
- Direct mode:
  - On accept, out_data <= channel sel, out_ch <= sel, out_last <= 1, out_valid <= 1 in the next cycle. Latency is 1 clock.
  - sel = 0 or sel > NUM_CH: out_data = 0, out_ch = 0, still one valid beat with out_last = 1. This is the null select.
- Scan mode:
  - On accept, the entire in_bus is copied into a snapshot register. Later changes to in_bus do not affect the beats.
  - Beat 1 is presented the next cycle: out_ch = 1, data = snapshot channel 1.
  - Each fire advances cnt by 1 and presents the next channel on the following cycle. There are no idle cycles while out_ready is held high.
  - out_last = 1 only when out_ch = NUM_CH. NUM_CH = 1 gives a single beat with out_last = 1.
- Backpressure: while out_valid && !out_ready, out_data, out_ch and out_last hold stable and cnt does not advance.
- out_valid never drops without a fire.
- Reset:
  - rst_n low asynchronously clears state to IDLE and sets out_valid = 0, out_data = 0, out_ch = 0, out_last = 0, cnt = 0, snapshot = 0, busy = 0.
  - in_ready is 1 while in reset and at release.
  - A reset during a scan aborts it with no further beats. The first accept after release starts fresh.
- No arithmetic is performed. out_data is a pure bit copy of the selected channel, with no sign extension.

Test Plan:
- Reset/idle: assert rst_n = 0 mid-cycle -> outputs zero immediately, in_ready = 1, busy = 0.
- Direct select, WIDTH = 8, NUM_CH = 7:
  - Set in_bus channels 1..7 = 0x11, 0x22, …, 0x77, sel = 5, mode = 0, one-cycle in_valid, out_ready = 1.
  - Expect the next cycle: out_valid = 1, out_data = 0x55, out_ch = 5, out_last = 1.
  - Repeat with sel = 0 -> out_data = 0x00, out_ch = 0.
- Scan with stall:
  - Use the same in_bus with mode = 1. After the accept, change in_bus to all 0xFF. Hold out_ready = 0 on beat 3 for 4 cycles.
  - Expect beats 0x11..0x77, out_ch = 1..7, beat 3 held stable as 0x33 during the stall, out_last only on 0x77.
  - in_ready = 0 until the last beat fires.
- Back-to-back:
  - Hold in_valid high and issue a scan request followed by a direct request with sel = 2, out_ready = 1.
  - Expect 7 scan beats immediately followed by 0x22 on the next cycle, with no bubble.
- Reset mid-scan:
  - Assert rst_n low after beat 4 fires.
  - Expect out_valid = 0 at once. After release, a direct request with sel = 7 returns 0x77 with out_ch = 7.
- Parameter sweep: WIDTH = 16, NUM_CH = 3, SEL_W = 2 -> scan gives out_ch 1, 2, 3 with out_last on 3; sel = 3 in direct mode is valid.

Source files
------------

// File: rtl/residue_select_serializer_if.sv
// Request/response bundle between the residue source, the selector/serializer
// and the converter core.
interface residue_select_serializer_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 7,
    parameter int SEL_W  = 3
);
    logic [NUM_CH*WIDTH-1:0] in_bus;
    logic                    in_valid;
    logic                    in_ready;
    logic                    mode;
    logic [SEL_W-1:0]        sel;
    logic [WIDTH-1:0]        out_data;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;
    logic                    out_last;
    logic                    busy;

    modport master (
        output in_bus, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_ch, out_valid, out_last, busy
    );

    modport slave (
        input  in_bus, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_ch, out_valid, out_last, busy
    );
endinterface

// File: rtl/residue_select_serializer.sv
// Registered residue-channel selector: emits one chosen channel (direct) or
// snapshots every channel and streams them 1..NUM_CH (scan).
module residue_select_serializer #(
    parameter int WIDTH  = 8,
    parameter int NUM_CH = 7,
    parameter int SEL_W  = 3
) (
    input logic                       clk,
    input logic                       rst_n,
    residue_select_serializer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t                  state;
    logic [SEL_W-1:0]        cnt;
    logic [NUM_CH*WIDTH-1:0] snap_q;
    logic [WIDTH-1:0]        data_q;
    logic [SEL_W-1:0]        ch_q;
    logic                    valid_q;
    logic                    last_q;

    logic                    accept;
    logic                    fire;
    logic                    sel_ok;
    logic [SEL_W-1:0]        cnt_nxt;

    // Out-of-range channel numbers (including 0) yield the null residue.
    function automatic logic [WIDTH-1:0] pick(input logic [NUM_CH*WIDTH-1:0] vec,
                                              input logic [SEL_W-1:0]        k);
        pick = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            if (k == SEL_W'(i)) pick = vec[(i-1)*WIDTH +: WIDTH];
        end
    endfunction

    assign bus.in_ready  = !valid_q || (bus.out_ready && last_q);
    assign accept        = bus.in_valid && bus.in_ready;
    assign fire          = valid_q && bus.out_ready;
    assign sel_ok        = (bus.sel != '0) && (bus.sel <= SEL_W'(NUM_CH));
    assign cnt_nxt       = cnt + SEL_W'(1);

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.busy      = (state != IDLE);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            // NOTE: the snapshot is cleared on reset so an aborted scan leaves no
            // stale residues behind.
            snap_q  <= '0;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else if (accept) begin
            // Accept is only possible when idle or when the final beat fires,
            // so a new request always replaces the current one outright.
            valid_q <= 1'b1;
            if (!bus.mode) begin
                state  <= DIRECT;
                cnt    <= '0;
                data_q <= sel_ok ? pick(bus.in_bus, bus.sel) : '0;
                ch_q   <= sel_ok ? bus.sel : '0;
                last_q <= 1'b1;
            end else begin
                state  <= SCAN;
                snap_q <= bus.in_bus;
                cnt    <= SEL_W'(1);
                data_q <= pick(bus.in_bus, SEL_W'(1));
                ch_q   <= SEL_W'(1);
                last_q <= (NUM_CH == 1);
            end
        end else if (fire) begin
            if (last_q) begin
                state   <= IDLE;
                valid_q <= 1'b0;
            end else begin
                cnt    <= cnt_nxt;
                data_q <= pick(snap_q, cnt_nxt);
                ch_q   <= cnt_nxt;
                last_q <= (cnt_nxt == SEL_W'(NUM_CH));
            end
        end
    end
endmodule

// File: tb/tb_residue_select_serializer.sv
// Scoreboard bench: requests push their expected beats, a negedge monitor pops
// and compares each fired beat; a second instance covers a narrow configuration.
module tb_residue_select_serializer;
    localparam int W = 8;
    localparam int N = 7;
    localparam int S = 3;

    typedef struct {
        logic [W-1:0] data;
        logic [S-1:0] ch;
        logic         last;
    } beat_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    beat_t q[$];
    logic  rand_ready = 1'b0;
    int    stall_ch   = 0;
    int    stall_left = 0;

    logic         prev_stall = 1'b0;
    logic [W-1:0] pd;
    logic [S-1:0] pc;
    logic         pl;

    residue_select_serializer_if #(.WIDTH(W), .NUM_CH(N), .SEL_W(S)) bus_if ();
    residue_select_serializer_if #(.WIDTH(16), .NUM_CH(3), .SEL_W(2)) bus2_if ();

    residue_select_serializer #(.WIDTH(W), .NUM_CH(N), .SEL_W(S)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_if)
    );
    residue_select_serializer #(.WIDTH(16), .NUM_CH(3), .SEL_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] rand_bus();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
        return r;
    endfunction

    // Reference model: the beats a request must produce, straight from the rules.
    function automatic void push_req(input bit m, input int s, input logic [N*W-1:0] b);
        beat_t e;
        if (!m) begin
            if (s >= 1 && s <= N) begin
                e.data = W'(b >> ((s - 1) * W));
                e.ch   = S'(s);
            end else begin
                e.data = '0;
                e.ch   = '0;
            end
            e.last = 1'b1;
            q.push_back(e);
        end else begin
            for (int k = 1; k <= N; k++) begin
                e.data = W'(b >> ((k - 1) * W));
                e.ch   = S'(k);
                e.last = (k == N);
                q.push_back(e);
            end
        end
    endfunction

    task automatic issue(input bit m, input int s, input logic [N*W-1:0] b,
                         input bit hold, input logic [N*W-1:0] post);
        bit accepted = 0;
        bus_if.mode     = m;
        bus_if.sel      = S'(s);
        bus_if.in_bus   = b;
        bus_if.in_valid = 1'b1;
        for (int t = 0; t < 300 && !accepted; t++) begin
            @(negedge clk);
            #1;
            if (bus_if.in_ready) begin
                push_req(m, s, b);
                accepted = 1;
            end
            @(posedge clk);
            #1;
        end
        check("accept_timeout", 64'(accepted), 64'd1);
        if (!hold) begin
            bus_if.in_valid = 1'b0;
            bus_if.in_bus   = post;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 500 && q.size() > 0; t++) @(negedge clk);
        check("drain_timeout", 64'(q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // out_ready driver: forced stall on a chosen channel, random, or held high.
    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_left > 0 && bus_if.out_valid && int'(bus_if.out_ch) == stall_ch) begin
                bus_if.out_ready = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                bus_if.out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus_if.out_ready = 1'b1;
            end
        end
    end

    // Monitor: stability under stall, handshake expectations and beat content.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check("hold_stable",
                          {bus_if.out_valid, bus_if.out_data, bus_if.out_ch, bus_if.out_last},
                          {1'b1, pd, pc, pl});
                check("valid_vs_pending", 64'(bus_if.out_valid), 64'(q.size() > 0));
                check("busy", 64'(bus_if.busy), 64'(q.size() > 0));
                check("in_ready", 64'(bus_if.in_ready),
                      64'((q.size() == 0) || (q.size() == 1 && bus_if.out_ready)));
                if (bus_if.out_valid && bus_if.out_ready && q.size() > 0) begin
                    e = q.pop_front();
                    check("beat", {bus_if.out_data, bus_if.out_ch, bus_if.out_last},
                          {e.data, e.ch, e.last});
                end
                prev_stall = bus_if.out_valid && !bus_if.out_ready;
                pd = bus_if.out_data;
                pc = bus_if.out_ch;
                pl = bus_if.out_last;
            end
        end
    end

    initial begin
        logic [N*W-1:0] base;
        bit seen;
        for (int k = 1; k <= N; k++) base[(k-1)*W +: W] = W'(k * 17);

        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_bus    = '0;
        bus_if.mode      = 1'b0;
        bus_if.sel       = '0;
        bus2_if.in_valid = 1'b0;
        bus2_if.in_bus   = '0;
        bus2_if.mode     = 1'b0;
        bus2_if.sel      = '0;
        bus2_if.out_ready = 1'b1;

        #12;
        check("rst_outputs", {bus_if.out_valid, bus_if.out_data, bus_if.out_ch, bus_if.out_last},
              '0);
        check("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Direct select, then null select.
        issue(1'b0, 5, base, 1'b0, rand_bus());
        drain();
        issue(1'b0, 0, base, 1'b0, rand_bus());
        drain();

        // Scan with bus changed after accept and a 4-cycle stall on channel 3.
        stall_ch   = 3;
        stall_left = 4;
        issue(1'b1, 0, base, 1'b0, '1);
        drain();
        check("stall_applied", 64'(stall_left), 64'd0);
        stall_ch = 0;

        // Back-to-back scan then direct with in_valid held high.
        issue(1'b1, 0, base, 1'b1, '0);
        issue(1'b0, 2, base, 1'b0, rand_bus());
        drain();

        // Reset right after beat 4 fires aborts the scan.
        issue(1'b1, 0, base, 1'b0, rand_bus());
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (bus_if.out_valid && bus_if.out_ch == S'(4)) seen = 1;
        end
        check("beat4_seen", 64'(seen), 64'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("midscan_rst_outputs",
              {bus_if.out_valid, bus_if.out_data, bus_if.out_ch, bus_if.out_last}, '0);
        check("midscan_rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        check("midscan_rst_busy", 64'(bus_if.busy), 64'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b0, 7, base, 1'b0, rand_bus());
        drain();

        // Randomised traffic with random backpressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 60; r++) begin
            issue(1'(($urandom % 2)), int'($urandom_range(0, 7)), rand_bus(),
                  1'($urandom % 2), rand_bus());
            if (!bus_if.in_valid) repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        bus_if.in_valid = 1'b0;
        rand_ready = 1'b0;
        drain();

        // Narrow configuration: WIDTH=16, NUM_CH=3, SEL_W=2.
        bus2_if.in_bus   = {16'h3333, 16'h2222, 16'h1111};
        bus2_if.mode     = 1'b1;
        bus2_if.in_valid = 1'b1;
        @(posedge clk);
        #1 bus2_if.in_valid = 1'b0;
        bus2_if.in_bus = '1;
        for (int k = 1; k <= 3; k++) begin
            check("p2_scan_beat",
                  {bus2_if.out_valid, bus2_if.out_data, bus2_if.out_ch, bus2_if.out_last},
                  {1'b1, 16'(k * 16'h1111), 2'(k), 1'(k == 3)});
            @(posedge clk);
            #1;
        end
        check("p2_scan_done", 64'(bus2_if.out_valid), 64'd0);
        bus2_if.in_bus   = {16'h3333, 16'h2222, 16'h1111};
        bus2_if.mode     = 1'b0;
        bus2_if.sel      = 2'd3;
        bus2_if.in_valid = 1'b1;
        @(posedge clk);
        #1 bus2_if.in_valid = 1'b0;
        check("p2_direct3",
              {bus2_if.out_valid, bus2_if.out_data, bus2_if.out_ch, bus2_if.out_last},
              {1'b1, 16'h3333, 2'd3, 1'b1});
        @(posedge clk);
        #1;
        check("p2_direct_done", 64'(bus2_if.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
